// File: rtl/rf_read_port.sv
// rf_read_port
//   Read-side controller for a register array built from dff_en write cells.
//   Read requests arrive over a valid/ready handshake. The addressed word is
//   taken from the array's parallel Q bus, and a write landing on the same edge
//   is forwarded so that the newest value is returned. Responses queue in a
//   2-entry FIFO that has its own valid/ready handshake.
//
// Ports
//   clk        rising-edge clock, shared with the array's write side
//   rst_n      asynchronous active-low reset
//   rf_q       array Q outputs; word i = rf_q[i*DATA_W +: DATA_W]
//   wr_en      array write enable (monitored for bypass)
//   wr_addr    array write address (monitored)
//   wr_data    array write data (monitored)
//   req_valid  read request present
//   req_addr   read address
//   req_ready  request accepted on this edge (FIFO not full)
//   resp_valid head of the FIFO holds a response
//   resp_data  read data (0 on error)
//   resp_err   1 when the address is >= NREGS
//   resp_ready consumer takes the head response on this edge
module rf_read_port #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int NREGS  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREGS*DATA_W-1:0] rf_q,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic                    req_valid,
  input  logic [ADDR_W-1:0]       req_addr,
  output logic                    req_ready,
  output logic                    resp_valid,
  output logic [DATA_W-1:0]       resp_data,
  output logic                    resp_err,
  input  logic                    resp_ready
);

  // One extra bit so that NREGS == 2**ADDR_W compares correctly
  localparam logic [ADDR_W:0] NREGS_EXT = (ADDR_W+1)'(NREGS);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state, state_nx;

  logic              push, pop;
  logic              load_head, load_tail, shift_head, clear_head;
  logic [DATA_W-1:0] rd_data;
  logic              rd_err;
  logic [DATA_W-1:0] head_data, tail_data;
  logic              head_err, tail_err;

  // Both handshake outputs come from registered state only
  assign req_ready  = (state != FULL);
  assign resp_valid = (state != EMPTY);
  assign resp_data  = head_data;
  assign resp_err   = head_err;

  assign push = req_valid & req_ready;
  assign pop  = resp_valid & resp_ready;

  // Word selection: range error first, then same-edge write forwarding,
  // then the stored array value
  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    if ({1'b0, req_addr} >= NREGS_EXT) begin
      rd_err = 1'b1;
    end else if (wr_en && (wr_addr == req_addr)) begin
      rd_data = wr_data;
    end else begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        if (req_addr == ADDR_W'(i)) rd_data = rf_q[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    load_head  = 1'b0;
    load_tail  = 1'b0;
    shift_head = 1'b0;
    clear_head = 1'b0;
    case (state)
      EMPTY: begin
        if (push) begin
          load_head = 1'b1;
          state_nx  = ONE;
        end
      end
      ONE: begin
        case ({push, pop})
          2'b10: begin
            load_tail = 1'b1;
            state_nx  = FULL;
          end
          2'b01: begin
            clear_head = 1'b1;
            state_nx   = EMPTY;
          end
          2'b11:   load_head = 1'b1;  // old head leaves, new word replaces it
          default: ;
        endcase
      end
      FULL: begin
        if (pop) begin
          shift_head = 1'b1;
          state_nx   = ONE;
        end
      end
      default: state_nx = EMPTY;
    endcase
  end

  // Entries are snapshots taken at push time; later writes never touch them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_data <= '0;
      head_err  <= 1'b0;
      tail_data <= '0;
      tail_err  <= 1'b0;
    end else begin
      if (load_head) begin
        head_data <= rd_data;
        head_err  <= rd_err;
      end else if (shift_head) begin
        head_data <= tail_data;
        head_err  <= tail_err;
      end else if (clear_head) begin
        head_data <= '0;
        head_err  <= 1'b0;
      end
      if (load_tail) begin
        tail_data <= rd_data;
        tail_err  <= rd_err;
      end
    end
  end

endmodule

// File: tb/tb_rf_read_port.sv
module tb_rf_read_port;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int NREGS  = 6;

  logic                    clk;
  logic                    rst_n;
  logic [NREGS*DATA_W-1:0] rf_q;
  logic                    wr_en;
  logic [ADDR_W-1:0]       wr_addr;
  logic [DATA_W-1:0]       wr_data;
  logic                    req_valid;
  logic [ADDR_W-1:0]       req_addr;
  logic                    req_ready;
  logic                    resp_valid;
  logic [DATA_W-1:0]       resp_data;
  logic                    resp_err;
  logic                    resp_ready;

  logic [DATA_W-1:0] regs [8];

  int n_cmp;
  int n_bad;

  rf_read_port #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .NREGS (NREGS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rf_q      (rf_q),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .resp_valid(resp_valid),
    .resp_data (resp_data),
    .resp_err  (resp_err),
    .resp_ready(resp_ready)
  );

  always_comb begin
    for (int i = 0; i < NREGS; i++) rf_q[i*DATA_W +: DATA_W] = regs[i];
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected responses for the streaming run over addresses 0..7 (6 and 7 out of range)
  logic [DATA_W-1:0] exp_d [8];
  logic              exp_e [8];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    regs[0] = 8'hA0; regs[1] = 8'hA1; regs[2] = 8'h11; regs[3] = 8'h5A;
    regs[4] = 8'hA4; regs[5] = 8'hA5; regs[6] = 8'hA6; regs[7] = 8'hA7;
    exp_d[0] = 8'hA0; exp_d[1] = 8'hA1; exp_d[2] = 8'h11; exp_d[3] = 8'h5A;
    exp_d[4] = 8'hA4; exp_d[5] = 8'hA5; exp_d[6] = 8'h00; exp_d[7] = 8'h00;
    for (int i = 0; i < 8; i++) exp_e[i] = (i >= 6);

    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    req_valid = 1'b1; req_addr = 3'd3; resp_ready = 1'b0;

    // Reset held with a pending request
    step(); step();
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_data", 32'(resp_data), 32'h00);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b0;
    rst_n = 1'b1;
    step(); step();
    check("post_rst_valid", 32'(resp_valid), 32'd0);
    check("post_rst_ready", 32'(req_ready), 32'd1);

    // Basic read
    req_valid = 1'b1; req_addr = 3'd3;
    step();
    req_valid = 1'b0;
    check("basic_valid", 32'(resp_valid), 32'd1);
    check("basic_data", 32'(resp_data), 32'h5A);
    check("basic_err", 32'(resp_err), 32'd0);
    resp_ready = 1'b1;
    step();
    check("basic_pop_empty", 32'(resp_valid), 32'd0);
    resp_ready = 1'b0;

    // Bypass hit
    req_valid = 1'b1; req_addr = 3'd2;
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'hC3;
    step();
    req_valid = 1'b0; wr_en = 1'b0;
    check("bypass_hit", 32'(resp_data), 32'hC3);
    resp_ready = 1'b1; step(); resp_ready = 1'b0;

    // Bypass miss (different write address)
    req_valid = 1'b1; req_addr = 3'd2;
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 8'hC3;
    step();
    req_valid = 1'b0; wr_en = 1'b0;
    check("bypass_miss", 32'(resp_data), 32'h11);
    resp_ready = 1'b1; step(); resp_ready = 1'b0;

    // Snapshot: a later write to a queued address leaves the entry alone
    req_valid = 1'b1; req_addr = 3'd4;
    step();
    req_valid = 1'b0;
    regs[4] = 8'h77; wr_en = 1'b1; wr_addr = 3'd4; wr_data = 8'h77;
    step();
    wr_en = 1'b0;
    check("snapshot_data", 32'(resp_data), 32'hA4);
    regs[4] = 8'hA4;
    resp_ready = 1'b1; step(); resp_ready = 1'b0;
    check("snapshot_pop", 32'(resp_valid), 32'd0);

    // Backpressure into FULL, third request held off
    req_valid = 1'b1; req_addr = 3'd0;
    step();
    req_addr = 3'd1;
    step();
    check("full_req_ready", 32'(req_ready), 32'd0);
    check("full_head", 32'(resp_data), 32'hA0);
    req_addr = 3'd5;
    step();
    check("full_hold_data", 32'(resp_data), 32'hA0);
    check("full_hold_ready", 32'(req_ready), 32'd0);
    req_valid = 1'b0; resp_ready = 1'b1;
    step();
    check("drain_second", 32'(resp_data), 32'hA1);
    check("drain_valid", 32'(resp_valid), 32'd1);
    check("drain_ready", 32'(req_ready), 32'd1);
    step();
    check("drain_empty", 32'(resp_valid), 32'd0);

    // Streaming push+pop every cycle, addresses 0..7
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1; req_addr = 3'(i);
      step();
      check($sformatf("stream_data_%0d", i), 32'(resp_data), 32'(exp_d[i]));
      check($sformatf("stream_err_%0d", i), 32'(resp_err), 32'(exp_e[i]));
      check($sformatf("stream_ready_%0d", i), 32'(req_ready), 32'd1);
    end
    req_valid = 1'b0;
    step();
    check("stream_end_empty", 32'(resp_valid), 32'd0);
    resp_ready = 1'b0;

    // Range error wins over a matching write
    req_valid = 1'b1; req_addr = 3'd7;
    wr_en = 1'b1; wr_addr = 3'd7; wr_data = 8'hEE;
    step();
    req_valid = 1'b0; wr_en = 1'b0;
    check("err_prio_err", 32'(resp_err), 32'd1);
    check("err_prio_data", 32'(resp_data), 32'h00);
    resp_ready = 1'b1; step(); resp_ready = 1'b0;

    // Asynchronous reset while FULL
    req_valid = 1'b1; req_addr = 3'd0;
    step();
    req_addr = 3'd1;
    step();
    req_valid = 1'b0;
    check("pre_async_full", 32'(req_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("async_valid", 32'(resp_valid), 32'd0);
    check("async_data", 32'(resp_data), 32'h00);
    check("async_ready", 32'(req_ready), 32'd1);
    #2 rst_n = 1'b1;
    step(); step();
    check("async_after_valid", 32'(resp_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
